// File: rtl/grant_buffer_fifo.sv
// grant_buffer_fifo
// Circular-buffer queue between a pipeline stage and the shared-resource
// arbiter. Words are queued while grant is withheld and drained one per
// granted cycle. Full / almost-full / empty / count decode from the count
// register only; overflow is sticky until reset or flush.
//
// Optional feature macro: GRANT_BUFFER_BYPASS_EN
//   defined   : a granted cycle with an empty buffer forwards in_data straight
//               to the output register (one-cycle latency).
//   undefined : the same cycle enqueues instead, and the word leaves on the
//               next granted cycle (no in_data -> out_data mux).
//
// Handshake semantics: in_valid qualifies in_data for exactly one cycle and is
// never held off; if the buffer is full and no pop happens the word is dropped
// and overflow latches. arbiter_grant permits one pop (or bypass) in the cycle
// it is high. out_valid is a single-cycle pulse per word with no backpressure.
module grant_buffer_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    arbiter_grant,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    arbiter_req,
    output logic                    to_stall_mgmt,
    output logic                    almost_full,
    output logic                    buffer_empty,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [AW-1:0] ONE_PTR   = AW'(1);

    // Storage and pointer state
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Registered outputs
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_arb_req;
    logic              r_overflow;

    // Per-cycle decisions
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_bypass;
    logic [CW-1:0]     w_count_next;
    logic              w_out_valid_next;
    logic [DATA_W-1:0] w_out_data_next;
    logic              w_req_next;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Decide whether this cycle pushes, pops, drops or bypasses
    always_comb begin
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_drop   = 1'b0;
        w_bypass = 1'b0;
        if (!arbiter_grant) begin
            // No grant: enqueue if there is room, otherwise the word is lost
            w_push = in_valid && !w_full;
            w_drop = in_valid && w_full;
        end else if (!w_empty) begin
            // Grant with data queued: pop, and the freed slot takes any new word
            w_pop  = 1'b1;
            w_push = in_valid;
        end else begin
`ifdef GRANT_BUFFER_BYPASS_EN
            // Grant while empty: forward the incoming word directly
            w_bypass = 1'b1;
`else
            // Grant while empty: no bypass path, so the word is queued
            w_push = in_valid;
`endif
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + ONE_CNT;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - ONE_CNT;
        end
    end

    // Next values of the registered output port
    always_comb begin
        w_out_valid_next = 1'b0;
        w_out_data_next  = r_out_data;
        if (w_pop) begin
            w_out_valid_next = 1'b1;
            w_out_data_next  = r_mem[r_rd_ptr];
        end else if (w_bypass) begin
            w_out_valid_next = in_valid;
            w_out_data_next  = in_data;
        end
        // Keep requesting while anything remains queued or is arriving
        w_req_next = (w_count_next != '0) || in_valid;
    end

    // Pointer, count and output register update; flush clears like reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_arb_req   <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_arb_req   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count     <= w_count_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_arb_req   <= w_req_next;
        end
    end

    // Storage write; contents are not reset since empty slots are never read
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign arbiter_req   = r_arb_req;
    assign overflow      = r_overflow;
    assign count         = r_count;
    assign buffer_empty  = w_empty;
    assign to_stall_mgmt = w_full;
    assign almost_full   = (r_count >= AFULL_CNT);

endmodule

// File: tb/tb_grant_buffer_fifo.sv
// tb_grant_buffer_fifo
// Directed scenarios followed by a randomized run, checked against a
// queue-based reference model of the buffer.
module tb_grant_buffer_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              arbiter_grant;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              arbiter_req;
    logic              to_stall_mgmt;
    logic              almost_full;
    logic              buffer_empty;
    logic              overflow;
    logic [3:0]        count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    grant_buffer_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .arbiter_grant(arbiter_grant),
        .flush(flush),
        .out_valid(out_valid),
        .out_data(out_data),
        .arbiter_req(arbiter_req),
        .to_stall_mgmt(to_stall_mgmt),
        .almost_full(almost_full),
        .buffer_empty(buffer_empty),
        .overflow(overflow),
        .count(count)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ov;
    logic [DATA_W-1:0] m_od;
    logic              m_req;
    logic              m_ovf;
    int                n_vec;
    int                n_err;

    task automatic model_reset();
        exp_q.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_req = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Behavioural view: a bounded FIFO queue plus the output register
    task automatic model_step(input logic v, input logic [DATA_W-1:0] d,
                              input logic g, input logic f);
        if (f) begin
            model_reset();
        end else begin
            if (!g) begin
                if (v) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(d);
                    else m_ovf = 1'b1;
                end
                m_ov = 1'b0;
            end else if (exp_q.size() > 0) begin
                m_od = exp_q.pop_front();
                m_ov = 1'b1;
                if (v) exp_q.push_back(d);
            end else begin
`ifdef GRANT_BUFFER_BYPASS_EN
                m_ov = v;
                m_od = d;
`else
                if (v) exp_q.push_back(d);
                m_ov = 1'b0;
`endif
            end
            m_req = (exp_q.size() != 0) || v;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                               input logic g, input logic f);
        in_valid      = v;
        in_data       = d;
        arbiter_grant = g;
        flush         = f;
        @(posedge clk);
        model_step(v, d, g, f);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h10 + i, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({out_valid, arbiter_req, overflow, to_stall_mgmt, almost_full, buffer_empty, count} !== {5'b00000, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL reset_flags got v=%0b req=%0b ovf=%0b full=%0b af=%0b emp=%0b cnt=%0d required 0 0 0 0 0 1 0",
                     out_valid, arbiter_req, overflow, to_stall_mgmt, almost_full, buffer_empty, count);
        end
        n_vec++;
        if (out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h required 0", out_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        n_vec++;
        if (buffer_empty !== 1'b1 || count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release got emp=%0b cnt=%0d required 1 0", buffer_empty, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0);
            n_vec++;
            if (count !== 4'(i + 1) || almost_full !== (i + 1 >= AFULL) || to_stall_mgmt !== (i + 1 == DEPTH)) begin
                n_err++;
                $display("FAIL fill_%0d got cnt=%0d af=%0b full=%0b required cnt=%0d af=%0b full=%0b",
                         i, count, almost_full, to_stall_mgmt, i + 1, (i + 1 >= AFULL), (i + 1 == DEPTH));
            end
        end
        drive_cycle(1'b1, 32'hFF, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            n_err++;
            $display("FAIL overflow got ovf=%0b cnt=%0d required 1 8", overflow, count);
        end
    endtask

    task automatic test_drain_wrap();
        logic [DATA_W-1:0] want;
        for (int i = 1; i <= 9; i++) begin
            drive_cycle(i == 1, 32'hB0, 1'b1, 1'b0);
            want = (i <= 8) ? 32'hA0 + (i - 1) : 32'hB0;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== want) begin
                n_err++;
                $display("FAIL drain_data_%0d got v=%0b d=%h required 1 %h", i, out_valid, out_data, want);
            end
            n_vec++;
            if (count !== 4'((i == 1) ? 8 : 9 - i)) begin
                n_err++;
                $display("FAIL drain_count_%0d got %0d required %0d", i, count, (i == 1) ? 8 : 9 - i);
            end
        end
        n_vec++;
        if (arbiter_req !== 1'b0 || buffer_empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end got req=%0b emp=%0b required 0 1", arbiter_req, buffer_empty);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_pulse got %0b required 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        drive_cycle(1'b1, 32'h1234, 1'b1, 1'b0);
`ifdef GRANT_BUFFER_BYPASS_EN
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234 || count !== 4'd0) begin
            n_err++;
            $display("FAIL bypass got v=%0b d=%h cnt=%0d required 1 1234 0", out_valid, out_data, count);
        end
`else
        n_vec++;
        if (out_valid !== 1'b0 || count !== 4'd1) begin
            n_err++;
            $display("FAIL nobypass_queue got v=%0b cnt=%0d required 0 1", out_valid, count);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234 || count !== 4'd0) begin
            n_err++;
            $display("FAIL nobypass_emit got v=%0b d=%h cnt=%0d required 1 1234 0", out_valid, out_data, count);
        end
`endif
    endtask

    task automatic test_idle();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || arbiter_req !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL idle got v=%0b req=%0b cnt=%0d required 0 0 0", out_valid, arbiter_req, count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (count !== 4'd5 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre got cnt=%0d ovf=%0b required 5 1", count, overflow);
        end
        drive_cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
        n_vec++;
        if (count !== 4'd0 || out_valid !== 1'b0 || arbiter_req !== 1'b0 || overflow !== 1'b0 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL flush got cnt=%0d v=%0b req=%0b ovf=%0b d=%h required 0 0 0 0 0",
                     count, out_valid, arbiter_req, overflow, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_leak_%0d got v=%0b d=%h required v=0", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_random();
        logic              v;
        logic              g;
        logic              f;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            g = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 60) == 0);
            d = $urandom;
            drive_cycle(v, d, g, f);
            n_vec++;
            if (out_valid !== m_ov || out_data !== m_od || arbiter_req !== m_req || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rand_out_%0d got v=%0b d=%h req=%0b ovf=%0b required v=%0b d=%h req=%0b ovf=%0b",
                         i, out_valid, out_data, arbiter_req, overflow, m_ov, m_od, m_req, m_ovf);
            end
            n_vec++;
            if (count !== 4'(exp_q.size()) || buffer_empty !== (exp_q.size() == 0) ||
                to_stall_mgmt !== (exp_q.size() == DEPTH) || almost_full !== (exp_q.size() >= AFULL)) begin
                n_err++;
                $display("FAIL rand_flags_%0d got cnt=%0d emp=%0b full=%0b af=%0b required cnt=%0d",
                         i, count, buffer_empty, to_stall_mgmt, almost_full, exp_q.size());
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        arbiter_grant = 1'b0;
        flush         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        test_reset();
        test_fill_overflow();
        test_drain_wrap();
        test_bypass();
        test_idle();
        test_flush();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
